// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time base: FSM state encodings and
// the default system clock frequency.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_SYS_CLK_HZ = 100_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV prescaler with count enable and synchronous clear. Emits a
// registered one-cycle pulse on the clock after the terminal count is seen
// while enabled.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic o_pulse
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_count;
  logic         r_pulse;

  // Count 0..DIV-1 while enabled, hold otherwise; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  // Terminal-count pulse, registered so it lands one cycle after the wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= en && !clr && (r_count == LAST);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Run/stop/clear controller for the stopwatch time base. Produces a gated
// count tick, a free-running scan tick and a one-cycle counter clear.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_tick_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ = DEFAULT_SYS_CLK_HZ,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned SCAN_HZ    = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_tick,
  output logic       o_scan_tick,
  output logic       o_clear,
  output logic       o_running,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

  localparam int unsigned DIV      = SYS_CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = SYS_CLK_HZ / SCAN_HZ;

  state_t r_state;
  state_t w_next;
  logic   r_running;
  logic   r_clear;
  logic   w_tick_en;
  logic   w_tick_clr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; clear beats run/stop in STOP, illegal code recovers to STOP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STOP: begin
        if (i_clear) begin
          w_next = ST_CLEAR;
        end else if (i_run_stop) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_run_stop) begin
          w_next = ST_STOP;
        end
      end
      ST_CLEAR: w_next = ST_STOP;
      default:  w_next = ST_STOP;
    endcase
  end

  // Status flags registered from the next state so they move with o_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_running <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_running <= (w_next == ST_RUN);
      r_clear   <= (w_next == ST_CLEAR);
    end
  end

  assign w_tick_en  = (r_state == ST_RUN);
  assign w_tick_clr = (r_state == ST_CLEAR);

  tick_prescaler #(.DIV(DIV)) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .en      (w_tick_en),
    .clr     (w_tick_clr),
    .o_pulse (o_tick)
  );

  tick_prescaler #(.DIV(SCAN_DIV)) u_scan_div (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .clr     (1'b0),
    .o_pulse (o_scan_tick)
  );

`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;

  // Lap toggles the display freeze only while running; entering CLEAR drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_hold <= 1'b0;
    end else if (w_next == ST_CLEAR) begin
      r_lap_hold <= 1'b0;
    end else if ((r_state == ST_RUN) && i_lap) begin
      r_lap_hold <= ~r_lap_hold;
    end
  end

  assign o_lap_hold = r_lap_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap = i_lap;
  assign o_lap_hold   = 1'b0;
`endif

  assign o_clear   = r_clear;
  assign o_running = r_running;
  assign o_state   = r_state;

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Self-checking bench for stopwatch_tick_ctrl (SYS_CLK_HZ=1000, DIV=10,
// SCAN_DIV=2). A cycle-level behavioural model tracks accumulated run time
// and free-running cycles; directed scenarios pin the model with literals.
module tb_stopwatch_tick_ctrl;

  localparam int DIV      = 10;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iRunStop = 1'b0;
  logic       iClear = 1'b0;
  logic       iLap = 1'b0;
  logic       oTick, oScanTick, oClear, oRunning, oLapHold;
  logic [1:0] oState;

  int testsRun = 0;
  int testsFailed = 0;

  stopwatch_tick_ctrl #(
    .SYS_CLK_HZ (1000),
    .TICK_HZ    (100),
    .SCAN_HZ    (500)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_run_stop  (iRunStop),
    .i_clear     (iClear),
    .i_lap       (iLap),
    .o_tick      (oTick),
    .o_scan_tick (oScanTick),
    .o_clear     (oClear),
    .o_running   (oRunning),
    .o_lap_hold  (oLapHold),
    .o_state     (oState)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0=stop, 1=run, 2=clear.
  int mState = 0;
  int mRunTotal = 0;
  int mScanCycles = 0;
  int mLap = 0;
  int expTick = 0, expScan = 0;
  bit modelReady = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    int prev;
    if (rst) begin
      mState = 0; mRunTotal = 0; mScanCycles = 0; mLap = 0;
      expTick = 0; expScan = 0; modelReady = 1'b1;
    end else begin
      prev = mState;
      expTick = 0;
      if (prev == 1) begin
        mRunTotal++;
        expTick = (mRunTotal % DIV == 0) ? 1 : 0;
      end else if (prev == 2) begin
        mRunTotal = 0;
      end
      mScanCycles++;
      expScan = (mScanCycles % SCAN_DIV == 0) ? 1 : 0;
      case (prev)
        0: mState = iClear ? 2 : (iRunStop ? 1 : 0);
        1: mState = iRunStop ? 0 : 1;
        default: mState = 0;
      endcase
`ifdef STOPWATCH_LAP_EN
      if (mState == 2) mLap = 0;
      else if (prev == 1 && iLap) mLap = 1 - mLap;
`endif
    end
  end

  // Single compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && modelReady) begin
      checkOutput("tick", int'(oTick), expTick);
      checkOutput("scan_tick", int'(oScanTick), expScan);
      checkOutput("state", int'(oState), mState);
      checkOutput("running", int'(oRunning), (mState == 1) ? 1 : 0);
      checkOutput("clear", int'(oClear), (mState == 2) ? 1 : 0);
      checkOutput("lap_hold", int'(oLapHold), mLap);
    end
  end

  // Present inputs for one clock edge, return at the following negedge.
  task automatic applyStimulus(input logic rs, input logic clr, input logic lap);
    iRunStop = rs; iClear = clr; iLap = lap;
    @(negedge clk);
    iRunStop = 1'b0; iClear = 1'b0; iLap = 1'b0;
  endtask

  // Cycles until the next o_tick (bounded); -1 if none within limit.
  task automatic cyclesToTick(input int limit, output int cycles);
    cycles = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (oTick) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic countTicks(input int n, output int ticks, output int scans);
    ticks = 0; scans = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (oTick) ticks++;
      if (oScanTick) scans++;
    end
  endtask

  initial begin
    int c, t, s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_state", int'(oState), 0);
    checkOutput("reset_outputs", int'({oTick, oScanTick, oClear, oRunning, oLapHold}), 0);

    // Idle after reset.
    countTicks(40, t, s);
    checkOutput("idle_ticks", t, 0);
    checkOutput("idle_scan_ticks", s, 20);

    // Run: first tick and steady rate.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_entry_running", int'(oRunning), 1);
    cyclesToTick(20, c);
    checkOutput("first_tick_latency", c, 10);
    countTicks(50, t, s);
    checkOutput("ticks_in_50", t, 5);

    // Pause with 4 counts accumulated, then resume.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    countTicks(30, t, s);
    checkOutput("stopped_ticks", t, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyclesToTick(20, c);
    checkOutput("resume_latency", c, 6);

    // Stop, then clear from STOP.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clear_state", int'(oState), 2);
    checkOutput("clear_pulse", int'(oClear), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_clear_state", int'(oState), 0);
    checkOutput("after_clear_pulse", int'(oClear), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyclesToTick(20, c);
    checkOutput("post_clear_latency", c, 10);

    // Clear ignored in RUN.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("run_clear_ignored", int'(oClear), 0);
    checkOutput("run_clear_state", int'(oState), 1);

    // Lap hold behaviour.
    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
    checkOutput("lap_set", int'(oLapHold), 1);
    countTicks(10, t, s);
    checkOutput("lap_ticks_continue", t, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_toggle_off", int'(oLapHold), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_ignored_stop", int'(oLapHold), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap_cleared", int'(oLapHold), 0);
`else
    checkOutput("lap_disabled", int'(oLapHold), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Simultaneous clear and run/stop in STOP: clear wins.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("simul_state", int'(oState), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("simul_not_running", int'(oRunning), 0);
    checkOutput("simul_back_stop", int'(oState), 0);

    // Asynchronous reset mid-count.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_state", int'(oState), 0);
    checkOutput("async_rst_running", int'(oRunning), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomized run; the compare process checks every cycle.
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(($urandom_range(11) == 0), ($urandom_range(23) == 0),
                    ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
